// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port round-robin arbiter and sequencer in front of the single-ported data_mem.
// Ports:
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_req_x/i_we_x          port x request (held until done) and store/load select
//   i_addr_x/i_wdata_x      port x byte address and store data
//   o_gnt_x/o_done_x/o_err_x  port x accept pulse, response pulse, reject qualifier
//   o_rdata_x               port x load data, held until that port's next load
//   o_mem_*                 registered data_mem address, write data, read/write strobes
//   i_mem_read_data         data_mem combinational read data (Z while o_mem_read is low)
module data_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter bit PRIO_A = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_a,
    input  logic        i_we_a,
    input  logic [31:0] i_addr_a,
    input  logic [31:0] i_wdata_a,
    output logic        o_gnt_a,
    output logic        o_done_a,
    output logic        o_err_a,
    output logic [31:0] o_rdata_a,
    input  logic        i_req_b,
    input  logic        i_we_b,
    input  logic [31:0] i_addr_b,
    input  logic [31:0] i_wdata_b,
    output logic        o_gnt_b,
    output logic        o_done_b,
    output logic        o_err_b,
    output logic [31:0] o_rdata_b,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_write_data,
    output logic        o_mem_read,
    output logic        o_mem_write,
    input  logic [31:0] i_mem_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_W) - 64'd1);
    state_t      r_state, w_state_nxt;
    logic        r_last_b, w_last_b;
    logic        r_sel_b, w_sel_b;
    logic        r_illegal, w_illegal;
    logic        r_gnt_a, r_gnt_b, r_done_a, r_done_b, r_err_a, r_err_b;
    logic        w_gnt_a, w_gnt_b, w_done_a, w_done_b, w_err_a, w_err_b;
    logic [31:0] r_rdata_a, r_rdata_b, w_rdata_a, w_rdata_b;
    logic [31:0] r_mem_address, r_mem_write_data, w_mem_address, w_mem_write_data;
    logic        r_mem_read, r_mem_write, w_mem_read, w_mem_write;
    logic        w_pick_b, w_we, w_bad;
    logic [31:0] w_addr, w_wdata;
    // B wins when it is alone, or on a tie in round-robin mode when A was served last
    assign w_pick_b = i_req_b & (~i_req_a | (~PRIO_A & ~r_last_b));
    assign w_we     = w_pick_b ? i_we_b    : i_we_a;
    assign w_addr   = w_pick_b ? i_addr_b  : i_addr_a;
    assign w_wdata  = w_pick_b ? i_wdata_b : i_wdata_a;
    assign w_bad    = (w_addr[1:0] != 2'b00) | ((w_addr >> ADDR_W) != 32'd0);
    always_comb begin
        w_state_nxt      = r_state;
        w_last_b         = r_last_b;
        w_sel_b          = r_sel_b;
        w_illegal        = r_illegal;
        w_gnt_a          = 1'b0;
        w_gnt_b          = 1'b0;
        w_done_a         = 1'b0;
        w_done_b         = 1'b0;
        w_err_a          = 1'b0;
        w_err_b          = 1'b0;
        w_rdata_a        = r_rdata_a;
        w_rdata_b        = r_rdata_b;
        w_mem_address    = r_mem_address;
        w_mem_write_data = r_mem_write_data;
        w_mem_read       = 1'b0;
        w_mem_write      = 1'b0;
        case (r_state)
            IDLE: if (i_req_a | i_req_b) begin
                w_state_nxt      = ACCESS;
                w_last_b         = w_pick_b;
                w_sel_b          = w_pick_b;
                w_illegal        = w_bad;
                w_gnt_a          = ~w_pick_b;
                w_gnt_b          = w_pick_b;
                w_mem_address    = w_addr & ADDR_MASK;
                w_mem_write_data = w_wdata;
                // illegal requests still take the ACCESS slot but never strobe memory
                w_mem_read       = ~w_bad & ~w_we;
                w_mem_write      = ~w_bad & w_we;
            end
            ACCESS: begin
                w_state_nxt = RESP;
                w_done_a    = ~r_sel_b;
                w_done_b    = r_sel_b;
                w_err_a     = ~r_sel_b & r_illegal;
                w_err_b     = r_sel_b & r_illegal;
                w_rdata_a   = (r_mem_read & ~r_sel_b) ? i_mem_read_data : r_rdata_a;
                w_rdata_b   = (r_mem_read & r_sel_b) ? i_mem_read_data : r_rdata_b;
            end
            RESP: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state          <= IDLE;
            r_last_b         <= 1'b1;
            r_sel_b          <= 1'b0;
            r_illegal        <= 1'b0;
            r_gnt_a          <= 1'b0;
            r_gnt_b          <= 1'b0;
            r_done_a         <= 1'b0;
            r_done_b         <= 1'b0;
            r_err_a          <= 1'b0;
            r_err_b          <= 1'b0;
            r_rdata_a        <= 32'd0;
            r_rdata_b        <= 32'd0;
            r_mem_address    <= 32'd0;
            r_mem_write_data <= 32'd0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_last_b         <= w_last_b;
            r_sel_b          <= w_sel_b;
            r_illegal        <= w_illegal;
            r_gnt_a          <= w_gnt_a;
            r_gnt_b          <= w_gnt_b;
            r_done_a         <= w_done_a;
            r_done_b         <= w_done_b;
            r_err_a          <= w_err_a;
            r_err_b          <= w_err_b;
            r_rdata_a        <= w_rdata_a;
            r_rdata_b        <= w_rdata_b;
            r_mem_address    <= w_mem_address;
            r_mem_write_data <= w_mem_write_data;
            r_mem_read       <= w_mem_read;
            r_mem_write      <= w_mem_write;
        end
    end
    assign o_gnt_a          = r_gnt_a;
    assign o_gnt_b          = r_gnt_b;
    assign o_done_a         = r_done_a;
    assign o_done_b         = r_done_b;
    assign o_err_a          = r_err_a;
    assign o_err_b          = r_err_b;
    assign o_rdata_a        = r_rdata_a;
    assign o_rdata_b        = r_rdata_b;
    assign o_mem_address    = r_mem_address;
    assign o_mem_write_data = r_mem_write_data;
    assign o_mem_read       = r_mem_read;
    assign o_mem_write      = r_mem_write;
endmodule
